// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for RV32M: one shift-add or restoring
// shift-subtract step per cycle, WIDTH cycles per operation, operands latched at start.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  // Operand conditioning at latch time
  logic             sgn_a, sgn_b, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
            (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg = sgn_a & A[WIDTH-1];
    b_neg = sgn_b & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
  end

  // One iteration step. Multiply: acc = {partial_hi, multiplier}, opb = multiplicand.
  // Divide: acc = {remainder, dividend/quotient}, opb = divisor.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fin;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    shifted  = acc_q[2*WIDTH-1:WIDTH-1];
    ge       = shifted >= {1'b0, opb_q};
    // True difference is below 2^WIDTH whenever ge holds, so modulo arithmetic is exact
    diff     = shifted[WIDTH-1:0] - opb_q;
    if (op_q[2]) begin
      acc_step = {(ge ? diff : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod = neg_q ? -acc_step : acc_step;
    quo  = acc_step[WIDTH-1:0];
    rem  = acc_step[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 fin = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin = dz_q ? '1 : (neg_q ? -quo : quo);
      default:                fin = rneg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = funct3;
          rneg_d  = a_neg;
          neg_d   = a_neg ^ b_neg;
          dz_d    = (B == '0);
          if (funct3[2]) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            opb_d = b_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            opb_d = a_mag;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = fin;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign Result = result_q;

endmodule
